// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// The round-robin option is selected by macro FIFO_ARB_ROUND_ROBIN_EN.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  localparam int OWNER_W    = $clog2(NUM_REQ_DEF);
  localparam int BEAT_CNT_W = $clog2(MAX_BURST_DEF) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter.
// Macro FIFO_ARB_ROUND_ROBIN_EN does not change this bundle.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OWNER_W = $clog2(NUM_REQ);

  // Handshake: req[i] is valid, ack[i] is ready-and-taken; a beat moves when both
  // are high in the same cycle. Producers hold req and data stable until acked
  // or withdrawn. fifo_write_req is a one-cycle write strobe, stalled by fifo_full.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      fifo_full;
  logic                      fifo_write_req;
  logic [DATA_W-1:0]         fifo_write_data;
  logic                      busy;
  logic [OWNER_W-1:0]        owner;

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_write_req, fifo_write_data, busy, owner
  );

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_write_req, fifo_write_data, busy, owner
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational winner selection for the write arbiter.
// FIFO_ARB_ROUND_ROBIN_EN: rotating priority from rr_ptr; otherwise lowest index wins.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
`ifdef FIFO_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
`endif
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int OW = $clog2(NUM_REQ);

`ifdef FIFO_ARB_ROUND_ROBIN_EN
  logic [NUM_REQ-1:0] rotated;
  logic [OW-1:0]      rot_idx;

  // Rotate so rr_ptr lands on bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    rotated = '0;
    rot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[(i + int'(rr_ptr)) % NUM_REQ];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) rot_idx = OW'(i);
    end
    winner = OW'((int'(rot_idx) + int'(rr_ptr)) % NUM_REQ);
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = OW'(i);
    end
  end
`endif

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between NUM_REQ producers in bursts of up to MAX_BURST beats.
// Define FIFO_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_write_arbiter_if.slave  bus,
  output state_t               dbg_state
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]      winner;
  logic [NUM_REQ-1:0] ack;
  logic               burst_end;

`ifdef FIFO_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] owner_inc;

  assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
`ifdef FIFO_ARB_ROUND_ROBIN_EN
    .rr_ptr (rr_ptr_q),
`endif
    .winner (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ack       = '0;
    burst_end = 1'b0;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // Arbitration takes this whole cycle; the first beat moves next cycle.
        if (|bus.req) begin
          state_d = BURST;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!bus.req[owner_q]) begin
          burst_end = 1'b1;
        end else if (!bus.fifo_full) begin
          ack[owner_q] = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == CW'(MAX_BURST - 1)) burst_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (burst_end) begin
      state_d = IDLE;
      owner_d = '0;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
      rr_ptr_d = owner_inc;
`endif
    end
  end

  assign bus.ack             = ack;
  assign bus.fifo_write_req  = |ack;
  assign bus.fifo_write_data = (|ack) ? bus.req_data[owner_q*DATA_W +: DATA_W] : '0;
  assign bus.busy            = (state_q == BURST);
  assign bus.owner           = owner_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized producers
// against a cycle-level reference model; honours FIFO_ARB_ROUND_ROBIN_EN.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int MB     = 4;
  localparam int OW     = 2;
  localparam int STAT_W = 2 + OW + N + 1;
  localparam int WR_W   = OW + DW;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset drive state
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [N-1:0]      req_v;
  logic [DW-1:0]     data_v [N];
  logic              full_v;
  logic              rst_v;
  logic [STAT_W-1:0] stat_q [$];
  logic [WR_W-1:0]   exp_q  [$];
  logic [WR_W-1:0]   obs_q  [$];
  int                n_checks;
  int                n_fail;
  bit                mon_en;

  // reference model state: burst flag, grant, beats written, next search start
  bit           m_burst;
  int           m_owner;
  int           m_beats;
  int           m_ptr;
  logic [N-1:0] m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef FIFO_ARB_ROUND_ROBIN_EN
    for (int off = 0; off < N; off++) begin
      if (r[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_cycle();
    logic [N-1:0] ack;
    bit           busy_out;
    int           own_out;
    bit           done;
    ack  = '0;
    done = 0;
    if (!rst_v) begin
      m_burst = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
      m_ack   = '0;
      stat_q.push_back('0);
      return;
    end
    busy_out = m_burst;
    own_out  = m_burst ? m_owner : 0;
    if (!m_burst) begin
      if (req_v != '0) begin
        m_owner = pick(req_v);
        m_beats = 0;
        m_burst = 1;
      end
    end else if (!req_v[m_owner]) begin
      done = 1;
    end else if (!full_v) begin
      ack[m_owner] = 1'b1;
      exp_q.push_back({OW'(m_owner), data_v[m_owner]});
      m_beats++;
      if (m_beats == MB) done = 1;
    end
    if (done) begin
      m_ptr   = (m_owner + 1) % N;
      m_burst = 0;
      m_owner = 0;
    end
    stat_q.push_back({busy_out, busy_out, OW'(own_out), ack, |ack});
    m_ack = ack;
  endtask

  // driver: one call = one clock cycle of stimulus plus its expected response
  task automatic step();
    @(posedge clk);
    #1;
    reset         = rst_v;
    bus.req       = req_v;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_v[i];
    bus.fifo_full = full_v;
    model_cycle();
  endtask

  task automatic reset_dut();
    req_v  = '0;
    full_v = 1'b0;
    rst_v  = 1'b0;
    step();
    rst_v  = 1'b1;
    step();
  endtask

  task automatic stream(input logic [N-1:0] mask, input int cycles);
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          req_v[i]  = 1'b1;
          data_v[i] = {4'(i), 4'(cnt[i])};
        end
      end
      step();
      for (int i = 0; i < N; i++) if (m_ack[i]) cnt[i]++;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [STAT_W-1:0] act_s;
    logic [WR_W-1:0]   obs;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cycle_status no expectation queued at %0t", $time);
      end else begin
        act_s = {bus.busy, dbg_state == BURST, bus.owner, bus.ack, bus.fifo_write_req};
        chk("cycle_status", act_s, stat_q.pop_front());
      end
      if (bus.fifo_write_req) begin
        obs = {bus.owner, bus.fifo_write_data};
        obs_q.push_back(obs);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write_beat unexpected write actual=%0h at %0t", obs, $time);
        end else begin
          chk("write_beat", obs, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int  k;
    int  stall;
    bit  got;
    n_checks = 0;
    n_fail   = 0;
    req_v    = '0;
    full_v   = 1'b0;
    rst_v    = 1'b0;
    for (int i = 0; i < N; i++) data_v[i] = '0;
    reset         = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    mon_en        = 1'b1;

    #2;
    chk("reset_ack", bus.ack, 0);
    chk("reset_wreq", bus.fifo_write_req, 0);
    chk("reset_wdata", bus.fifo_write_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_owner", bus.owner, 0);
    step();
    rst_v = 1'b1;
    step();

    // single producer, six beats 0x10..0x15
    obs_q.delete();
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      req_v     = 4'b0001;
      data_v[0] = 8'(8'h10 + k);
      step();
      if (m_ack[0]) k++;
    end
    req_v = '0;
    step();
    step();
    chk("single_beats", k, 6);
    chk("single_count", obs_q.size(), 6);
    for (int j = 0; j < 6 && j < obs_q.size(); j++) chk("single_data", obs_q[j], {2'd0, 8'(8'h10 + j)});

    // all four requesting continuously for five bursts
    reset_dut();
    obs_q.delete();
    stream(4'hF, 25);
    req_v = '0;
    step();
    step();
    chk("rr_count", obs_q.size(), 20);
    for (int j = 0; j < 20 && j < obs_q.size(); j++) begin
`ifdef FIFO_ARB_ROUND_ROBIN_EN
      chk("rr_owner", obs_q[j][DW +: OW], (j / 4) % 4);
`else
      chk("rr_owner", obs_q[j][DW +: OW], 0);
`endif
    end

    // FIFO full for three cycles while beat 2 is offered
    obs_q.delete();
    k     = 0;
    stall = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      req_v     = 4'b0001;
      data_v[0] = 8'(8'h20 + k);
      full_v    = (k == 2 && stall < 3);
      if (full_v) stall++;
      step();
      if (full_v) begin
        #1;
        chk("stall_wreq", bus.fifo_write_req, 0);
        chk("stall_ack", bus.ack, 0);
        chk("stall_owner", bus.owner, 0);
      end
      if (m_ack[0]) k++;
    end
    full_v = 1'b0;
    req_v  = '0;
    step();
    step();
    chk("stall_count", obs_q.size(), 4);
    for (int j = 0; j < 4 && j < obs_q.size(); j++) chk("stall_data", obs_q[j][DW-1:0], 8'(8'h20 + j));

    // owner 2 withdraws after one beat
    reset_dut();
    req_v     = 4'b0100;
    data_v[2] = 8'h42;
    got       = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      got = m_ack[2];
    end
    chk("withdraw_first_beat", got, 1);
    req_v     = 4'b1001;
    data_v[0] = 8'h50;
    data_v[3] = 8'h53;
    step();
    #1;
    chk("withdraw_no_write", bus.fifo_write_req, 0);
    step();
    #1;
    chk("withdraw_idle", bus.busy, 0);
    step();
    #1;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
    chk("withdraw_next_owner", bus.owner, 3);
`else
    chk("withdraw_next_owner", bus.owner, 0);
`endif
    req_v = '0;
    step();
    step();

    // asynchronous reset in beat 1 of a burst
    reset_dut();
    stream(4'b0100, 6);
    req_v = '0;
    step();
    req_v     = 4'b1000;
    data_v[3] = 8'h71;
    step();
    step();
    data_v[3] = 8'h72;
    rst_v     = 1'b0;
    step();
    #1;
    chk("arst_ack", bus.ack, 0);
    chk("arst_wreq", bus.fifo_write_req, 0);
    chk("arst_wdata", bus.fifo_write_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_owner", bus.owner, 0);
    rst_v     = 1'b1;
    req_v     = 4'b1110;
    data_v[1] = 8'h81;
    data_v[2] = 8'h82;
    step();
    step();
    #1;
    chk("arst_restart_owner", bus.owner, 1);
    req_v = '0;
    step();
    step();

    // producer 1 toggles while producer 0 owns the port
    reset_dut();
    obs_q.delete();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      req_v[0]  = (c < 5);
      data_v[0] = 8'(8'h30 + k);
      req_v[1]  = (c >= 1 && c <= 4) ? c[0] : 1'b0;
      data_v[1] = 8'hEE;
      step();
      if (m_ack[0]) k++;
      if (c >= 1 && c <= 4) begin
        #1;
        chk("iso_ack1", bus.ack[1], 0);
      end
    end
    req_v = '0;
    step();
    chk("iso_count", obs_q.size(), 4);
    for (int j = 0; j < 4 && j < obs_q.size(); j++) chk("iso_data", obs_q[j], {2'd0, 8'(8'h30 + j)});

    // randomized producers, FIFO back-pressure and occasional resets
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_v[i]  = 1'b1;
            data_v[i] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      full_v = ($urandom_range(0, 3) == 0);
      rst_v  = ($urandom_range(0, 399) != 0);
      step();
      for (int i = 0; i < N; i++) if (m_ack[i]) req_v[i] = 1'b0;
    end
    rst_v  = 1'b1;
    full_v = 1'b0;
    req_v  = '0;
    step();
    step();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("stat_q_drained", stat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
